// File: rtl/jk_bank_driver.sv
// Drives J/K and sync_reset of an external JK flip-flop bank forming a modulo-MODULUS
// up/down counter. Optional feedback checking is built when JK_FAULT_CHECK_EN is defined.
module jk_bank_driver #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             async_reset_n,
    input  logic             sync_clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             up_down,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic             flop_sync_reset,
    output logic [WIDTH-1:0] expected_q,
    output logic             terminal_count,
    output logic             fault,
    output logic [1:0]       state_dbg
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

`ifdef JK_FAULT_CHECK_EN
    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] nv;

`ifdef JK_FAULT_CHECK_EN
    logic fault_q, fault_d;
`endif

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            state_q <= ST_INIT;
            count_q <= '0;
`ifdef JK_FAULT_CHECK_EN
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
`ifdef JK_FAULT_CHECK_EN
            fault_q <= fault_d;
`endif
        end
    end

    always_comb begin
        state_d         = state_q;
        count_d         = count_q;
        nv              = count_q;
        J               = '0;
        K               = '0;
        flop_sync_reset = 1'b0;
        terminal_count  = 1'b0;
`ifdef JK_FAULT_CHECK_EN
        fault_d         = fault_q;
`endif
        case (state_q)
            ST_INIT: begin
                // Bank is cleared on the same edge the mirror enters RUN at zero.
                flop_sync_reset = 1'b1;
                count_d         = '0;
                state_d         = ST_RUN;
            end
            ST_RUN: begin
                if (sync_clear) begin
                    flop_sync_reset = 1'b1;
                    nv              = '0;
                end else if (load) begin
                    nv = (load_value > MAX_VAL) ? MAX_VAL : load_value;
                end else if (enable) begin
                    if (up_down) begin
                        nv = (count_q == MAX_VAL) ? '0 : count_q + WIDTH'(1);
                    end else begin
                        nv = (count_q == '0) ? MAX_VAL : count_q - WIDTH'(1);
                    end
                    terminal_count = up_down ? (count_q == MAX_VAL) : (count_q == '0);
                end
                // Excitation with don't-cares resolved to 0: set or reset only, never toggle.
                if (!sync_clear) begin
                    J = ~count_q & nv;
                    K = count_q & ~nv;
                end
                count_d = nv;
`ifdef JK_FAULT_CHECK_EN
                if (!sync_clear && (q_fb != count_q)) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                end
`endif
            end
`ifdef JK_FAULT_CHECK_EN
            ST_FAULT: begin
                if (sync_clear) begin
                    flop_sync_reset = 1'b1;
                    count_d         = '0;
                    fault_d         = 1'b0;
                    state_d         = ST_RUN;
                end
            end
`endif
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign expected_q = count_q;
    assign state_dbg  = state_q;

`ifdef JK_FAULT_CHECK_EN
    assign fault = fault_q;
`else
    logic unused_q_fb;
    assign unused_q_fb = ^q_fb;
    assign fault       = 1'b0;
`endif

endmodule

// File: tb/tb_jk_bank_driver.sv
// Randomised and directed bench for jk_bank_driver against a behavioural counter model
// and a behavioural JK flop bank. Define JK_FAULT_CHECK_EN to include the fault scenario.
module tb_jk_bank_driver;

    localparam int W = 4;
    localparam int M = 10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sync_clear = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_value = '0;
    logic         enable = 1'b0;
    logic         up_down = 1'b1;
    logic [W-1:0] q_fb;
    logic [W-1:0] J, K, expected_q;
    logic         flop_sync_reset, terminal_count, fault;
    logic [1:0]   state_dbg;

    logic [W-1:0] bank_q = '0;
    logic         force_en = 1'b0;
    logic [W-1:0] force_val = '0;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Behavioural model state
    bit m_init = 1'b1;
    bit m_fault = 1'b0;
    int m_cnt = 0;

    assign q_fb = force_en ? force_val : bank_q;

    jk_bank_driver #(.WIDTH(W), .MODULUS(M)) dut (
        .clk(clk), .async_reset_n(rst_n), .sync_clear(sync_clear), .load(load),
        .load_value(load_value), .enable(enable), .up_down(up_down), .q_fb(q_fb),
        .J(J), .K(K), .flop_sync_reset(flop_sync_reset), .expected_q(expected_q),
        .terminal_count(terminal_count), .fault(fault), .state_dbg(state_dbg)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, actual, required, $time);
        end
    endtask

    // Behavioural JK bank
    always @(posedge clk) begin
        for (int i = 0; i < W; i++) begin
            if (flop_sync_reset) bank_q[i] <= 1'b0;
            else if (J[i] && K[i]) bank_q[i] <= ~bank_q[i];
            else if (J[i]) bank_q[i] <= 1'b1;
            else if (K[i]) bank_q[i] <= 1'b0;
        end
    end

    function automatic int model_nv();
        if (sync_clear) return 0;
        if (load) return (int'(load_value) > M - 1) ? M - 1 : int'(load_value);
        if (enable) return up_down ? (m_cnt + 1) % M : (m_cnt + M - 1) % M;
        return m_cnt;
    endfunction

    // Model update
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_init = 1'b1; m_fault = 1'b0; m_cnt = 0;
        end else if (m_init) begin
            m_init = 1'b0; m_cnt = 0;
        end else if (m_fault) begin
            if (sync_clear) begin m_fault = 1'b0; m_cnt = 0; end
        end else begin
`ifdef JK_FAULT_CHECK_EN
            if (!sync_clear && int'(q_fb) != m_cnt) m_fault = 1'b1;
`endif
            m_cnt = model_nv();
        end
    end

    // Compare process: every cycle on the falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            int nv;
            logic [W-1:0] pv, nb, ej, ek;
            int ers, etc;
            ej = '0; ek = '0; ers = 0; etc = 0;
            pv = W'(m_cnt);
            if (m_init) begin
                ers = 1;
            end else if (m_fault) begin
                ers = int'(sync_clear);
            end else begin
                nv = model_nv();
                nb = W'(nv);
                ers = int'(sync_clear);
                for (int i = 0; i < W; i++) begin
                    if (!sync_clear && !pv[i] && nb[i]) ej[i] = 1'b1;
                    if (!sync_clear && pv[i] && !nb[i]) ek[i] = 1'b1;
                end
                if (enable && !load && !sync_clear)
                    etc = up_down ? int'(m_cnt == M - 1) : int'(m_cnt == 0);
            end
            check("expected_q", expected_q, m_cnt);
            check("J", J, ej);
            check("K", K, ek);
            check("flop_sync_reset", flop_sync_reset, ers);
            check("terminal_count", terminal_count, etc);
            check("fault", fault, int'(m_fault));
            check("no_toggle", int'(J & K), 0);
            if (!m_init && !m_fault && !force_en && rst_n)
                check("bank_vs_mirror", bank_q, expected_q);
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sc, input bit ld, input int lv, input bit en, input bit ud);
        sync_clear = sc; load = ld; load_value = W'(lv); enable = en; up_down = ud;
    endtask

    initial begin
        int seq[12];
        seq = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};

        drive(0, 0, 0, 0, 1);
        #1;
        check("reset_expected_q", expected_q, 0);
        check("reset_fsr", flop_sync_reset, 1);
        check("reset_J", J, 0);
        tick(); tick();
        chk_en = 1'b1;
        rst_n = 1'b1;
        drive(0, 0, 0, 1, 1);
        #1;
        check("init_fsr", flop_sync_reset, 1);
        check("init_J", J, 0);
        tick();
        for (int k = 0; k < 12; k++) begin
            #1;
            check("up_seq_q", expected_q, seq[k]);
            check("up_seq_tc", terminal_count, int'(seq[k] == 9));
            check("up_seq_fsr", flop_sync_reset, 0);
            tick();
        end

        drive(1, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 1, 0); #1;
        check("down_wrap_J", J, 4'b1001);
        check("down_wrap_K", K, 0);
        check("down_wrap_tc", terminal_count, 1);
        tick(); #1;
        check("down_wrap_q", expected_q, 9);

        drive(0, 1, 7, 0, 1); tick();
        drive(0, 0, 0, 1, 1); #1;
        check("step7_J", J, 4'b1000);
        check("step7_K", K, 4'b0111);
        tick(); #1;
        check("step7_q", expected_q, 8);

        drive(0, 1, 13, 1, 1); tick(); #1;
        check("load_sat_q", expected_q, 9);
        drive(1, 1, 5, 1, 1); #1;
        check("clr_load_fsr", flop_sync_reset, 1);
        tick(); #1;
        check("clr_load_q", expected_q, 0);

        drive(0, 0, 0, 1, 1);
        repeat (M) tick();
        drive(0, 0, 0, 1, 0);
        repeat (M) tick();

        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 15), $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
            tick();
        end

        drive(0, 1, 6, 0, 1); tick();
        drive(0, 0, 0, 1, 1); #1;
        check("pre_async_q", expected_q, 6);
        rst_n = 1'b0; #1;
        check("async_J", J, 0);
        check("async_K", K, 0);
        check("async_fsr", flop_sync_reset, 1);
        check("async_q", expected_q, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        repeat (5) tick(); #1;
        check("post_async_q", expected_q, 5);

`ifdef JK_FAULT_CHECK_EN
        drive(1, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 1, 1);
        repeat (3) tick();
        force_val = 4'b0111; force_en = 1'b1; #1;
        check("pre_fault_q", expected_q, 3);
        tick();
        force_en = 1'b0; #1;
        check("fault_set", fault, 1);
        check("fault_J", J, 0);
        check("fault_K", K, 0);
        tick(); #1;
        check("fault_hold_q", expected_q, 4);
        drive(1, 0, 0, 1, 1); #1;
        check("fault_clr_fsr", flop_sync_reset, 1);
        tick();
        drive(0, 0, 0, 1, 1); #1;
        check("fault_cleared", fault, 0);
        check("fault_clr_q", expected_q, 0);
        tick(); #1;
        check("resume_q", expected_q, 1);
`endif

        drive(0, 0, 0, 0, 1);
        tick();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
